// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises IF reads and LSU reads/writes onto one MEM port.
// The MEM strobes are only ever non-zero during the one-cycle ACCESS window.
//
// state    | meaning
// ---------|----------------------------------------------------------
// S_IDLE   | waiting for a request; combinational round-robin grant
// S_ACCESS | one-cycle memory access using the latched request
// S_RESP   | response held for the owner until its resp_ready
module mem_arbiter #(
    parameter bit LSU_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [63:0] if_req_addr,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [63:0] if_resp_data,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [63:0] lsu_req_addr,
    input  logic        lsu_req_we,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wmask,
    output logic        lsu_resp_valid,
    input  logic        lsu_resp_ready,
    output logic [63:0] lsu_resp_data,
    output logic [63:0] mem_addr,
    output logic        mem_ce,
    output logic        mem_we,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [63:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSU = 1'b1;
    // last_grant starts at the requester that should lose the first contention
    localparam logic LAST_GRANT_RST = LSU_FIRST ? OWNER_IF : OWNER_LSU;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_owner;
    logic [63:0] r_addr;
    logic        r_we;
    logic [63:0] r_wdata;
    logic [7:0]  r_wmask;
    logic [63:0] r_resp;
    logic        r_if_resp_valid;
    logic        r_lsu_resp_valid;

    logic w_idle;
    logic w_access;
    logic w_grant_if;
    logic w_grant_lsu;
    logic w_resp_done;

    assign w_idle      = (r_state == S_IDLE);
    assign w_access    = (r_state == S_ACCESS);
    assign w_grant_lsu = lsu_req_valid && (!if_req_valid || (r_last_grant == OWNER_IF));
    assign w_grant_if  = if_req_valid && (!lsu_req_valid || (r_last_grant == OWNER_LSU));
    assign w_resp_done = (r_if_resp_valid && if_resp_ready) ||
                         (r_lsu_resp_valid && lsu_resp_ready);

    // ready is gated by rst so nothing is accepted while reset is held
    assign if_req_ready  = !rst && w_idle && w_grant_if;
    assign lsu_req_ready = !rst && w_idle && w_grant_lsu;

    assign if_resp_valid  = r_if_resp_valid;
    assign lsu_resp_valid = r_lsu_resp_valid;
    assign if_resp_data   = r_if_resp_valid  ? r_resp : 64'd0;
    assign lsu_resp_data  = r_lsu_resp_valid ? r_resp : 64'd0;

    assign mem_ce    = w_access;
    assign mem_we    = w_access && r_we;
    assign mem_addr  = w_access ? r_addr  : 64'd0;
    assign mem_wdata = w_access ? r_wdata : 64'd0;
    assign mem_wmask = (w_access && r_we) ? r_wmask : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_last_grant     <= LAST_GRANT_RST;
            r_owner          <= OWNER_IF;
            r_addr           <= 64'd0;
            r_we             <= 1'b0;
            r_wdata          <= 64'd0;
            r_wmask          <= 8'h00;
            r_resp           <= 64'd0;
            r_if_resp_valid  <= 1'b0;
            r_lsu_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_lsu) begin
                        r_owner      <= OWNER_LSU;
                        r_last_grant <= OWNER_LSU;
                        r_addr       <= lsu_req_addr;
                        r_we         <= lsu_req_we;
                        r_wdata      <= lsu_req_wdata;
                        r_wmask      <= lsu_req_we ? lsu_req_wmask : 8'h00;
                        r_state      <= S_ACCESS;
                    end else if (w_grant_if) begin
                        r_owner      <= OWNER_IF;
                        r_last_grant <= OWNER_IF;
                        r_addr       <= if_req_addr;
                        r_we         <= 1'b0;
                        r_wdata      <= 64'd0;
                        r_wmask      <= 8'h00;
                        r_state      <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    r_resp           <= r_we ? 64'd0 : mem_rdata;
                    r_if_resp_valid  <= (r_owner == OWNER_IF);
                    r_lsu_resp_valid <= (r_owner == OWNER_LSU);
                    r_state          <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_if_resp_valid  <= 1'b0;
                        r_lsu_resp_valid <= 1'b0;
                        r_state          <= S_IDLE;
                    end
                end
                default: begin
                    r_if_resp_valid  <= 1'b0;
                    r_lsu_resp_valid <= 1'b0;
                    r_state          <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer between instruction fetch (IF) and load/store unit (LSU) in the npc core. It serialises both requesters onto the one `MEM` DPI port (`pmem_read`/`pmem_write`), drives `ce/we/wmask` only during a one-cycle access window, and registers read data into a response buffer returned over a valid/ready handshake. Since `MEM` writes whenever `wmask` is non-zero, the arbiter is the sole guard against spurious writes.

## Interface
- `LSU_FIRST`, default 1: the requester favoured on the first contention after reset (1 = LSU, 0 = IF).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-high reset
- `if_req_valid`  in  1  IF read request
- `if_req_ready`  out  1  IF request accepted this cycle
- `if_req_addr`  in  64  IF read address
- `if_resp_valid`  out  1  IF read data valid
- `if_resp_ready`  in  1  IF consumes response
- `if_resp_data`  out  64  IF read data
- `lsu_req_valid`  in  1  LSU request
- `lsu_req_ready`  out  1  LSU request accepted this cycle
- `lsu_req_addr`  in  64  LSU address
- `lsu_req_we`  in  1  1 = write, 0 = read
- `lsu_req_wdata`  in  64  write data
- `lsu_req_wmask`  in  8  byte write mask
- `lsu_resp_valid`  out  1  LSU response (read data or write ack)
- `lsu_resp_ready`  in  1  LSU consumes response
- `lsu_resp_data`  out  64  LSU read data; 0 for a write ack
- `mem_addr`  out  64  to `MEM.addr`
- `mem_ce`  out  1  to `MEM.ce`
- `mem_we`  out  1  to `MEM.we`
- `mem_wdata`  out  64  to `MEM.wdata`
- `mem_wmask`  out  8  to `MEM.wmask`
- `mem_rdata`  in  64  from `MEM.rdata` (combinational read)

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - Grant logic is combinational from the two `*_req_valid` signals.
  - One valid request: grant it.
  - Both valid: grant the requester that was **not** granted last (round-robin `last_grant` register).
  - Reset value of `last_grant`: IF when `LSU_FIRST`=1, LSU when `LSU_FIRST`=0.
  - `*_req_ready` is high only for the granted requester. The handshake fires that cycle.
  - On the handshake, latch into request registers: addr, we (forced 0 for IF), wdata, wmask (forced 0 for reads), and the owner.
  - Update `last_grant` and go to ACCESS.
  - No valid request: stay in IDLE.
- **ACCESS (exactly 1 cycle):**
  - `mem_ce`=1, `mem_addr`=latched addr, `mem_we`=latched we.
  - `mem_wdata`=latched wdata. `mem_wmask`=latched wmask for writes, 8'h00 for reads.
  - For reads, capture `mem_rdata` into the response register at the end of the cycle. For writes, load 0.
  - Go to RESP.
- **RESP:**
  - `<owner>_resp_valid`=1 and `<owner>_resp_data`=response register; both are held stable until `<owner>_resp_ready`.
  - On `resp_valid && resp_ready`: go to IDLE.
  - New requests are not accepted in RESP. Both `*_req_ready` are 0.
- **Outside ACCESS:** `mem_ce`=0, `mem_we`=0, `mem_wmask`=8'h00, `mem_addr`=0, `mem_wdata`=0. This is mandatory: it prevents unintended `pmem_write`.
- **Non-owner response:** the non-owner `*_resp_valid` is always 0. Its `*_resp_data` is 0.
- **Addresses:** passed unmodified. No alignment checks or byte steering; the LSU pre-shifts wdata and wmask.
- **Reset (async, any state, including mid-ACCESS):**
  - FSM returns to IDLE and `last_grant` returns to its reset value.
  - Request and response registers clear to 0.
  - All outputs go to 0 immediately. Any in-flight access is abandoned and no response is issued.

## Timing
- The request handshake in cycle N gives ACCESS in cycle N+1 and `resp_valid` in cycle N+2 (minimum). With `resp_ready` high in N+2, the next handshake can occur in N+3.
- Peak throughput is one access per 3 cycles.
- `*_req_ready` depends combinationally on `*_req_valid`. Requesters must not make valid depend on ready.
- A request deasserted before its handshake is never issued.
- `*_resp_valid` is a registered output. `mem_*` outputs are decoded from registered state only.
- Contention: alternating grants, so neither requester waits more than one foreign transaction.

## Test plan
- **IF read, no contention:** `if_req_addr`=0x8000_0000, memory word 0x0000_0413_0000_0297. Required: `if_req_ready`=1 in N; in N+1 `mem_ce`=1, `mem_we`=0, `mem_wmask`=0; `if_resp_valid`=1 in N+2 with data 0x0000_0413_0000_0297.
- **LSU write:** addr 0x8000_0100, wdata 0xDEAD_BEEF_0000_0000, wmask 8'hF0. Required: `mem_wmask`=8'hF0 only in N+1; `lsu_resp_valid` in N+2 with data 0. A subsequent LSU read of 0x8000_0100 returns 0xDEAD_BEEF_xxxx_xxxx, with the low bytes unchanged.
- **Contention after reset (`LSU_FIRST`=1):** both valid continuously. Required grant order LSU, IF, LSU, IF, with one grant per 3 cycles.
- **Response backpressure:** hold `if_resp_ready`=0 for 5 cycles with `lsu_req_valid`=1. Required: `if_resp_valid`/data stable; `lsu_req_ready`=0 throughout; `mem_wmask`=0 and `mem_ce`=0; LSU is granted the cycle after the IF handshake completes.
- **Reset in ACCESS of a write:** assert `rst` mid-cycle. Required: `mem_wmask`, `mem_ce` and all `*_resp_valid` drop to 0 immediately; after release the FSM is in IDLE and no response is issued for the aborted request.
- **Idle guard:** no requests for 20 cycles. Required: `mem_wmask`=8'h00, `mem_we`=0, `mem_ce`=0 every cycle, and the memory contents are unchanged.
